// File: rtl/rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares one combinational ROM between two requesters. A requester asks for a
// burst of 1..2^ADDR_W consecutive words. The arbiter grants one requester at a
// time, walks the ROM address one word per cycle, and returns registered data
// with a valid strobe and an end-of-burst flag. The block is the only driver
// of the ROM address.
//
// Configuration macro:
//   ROM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                             (the requester that was not last served wins)
//                  undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   req0/req1        burst request, held high until the matching grant
//   addr0/addr1      burst start address, sampled with the grant
//   len0/len1        burst length minus one, sampled with the grant
//   gnt0/gnt1        one-cycle grant pulse
//   vld0/vld1        data beat valid
//   data0/data1      registered read data, held between beats
//   done0/done1      high with the last beat of a burst
//   rom_addr         address to the ROM
//   rom_data         ROM output, combinational in rom_addr
//   busy             high while a burst is in progress
// -----------------------------------------------------------------------------
module rom_read_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len0,
    input  logic [ADDR_W-1:0] len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              vld0,
    output logic              vld1,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic              done0,
    output logic              done1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                vld0_q, vld0_d;
    logic                vld1_q, vld1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   data0_q, data0_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic                busy_q, busy_d;

    logic                winner_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [ADDR_W-1:0]   win_len_s;

    // Arbitration: pick which requester wins when the FSM is idle
    always_comb begin
        winner_s = 1'b0;
        if (req0 && req1) begin
`ifdef ROM_ARB_RR_EN
            // Serve whoever was not served last time.
            winner_s = ~last_owner_q;
`else
            winner_s = 1'b0;
`endif
        end else if (req1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Mux the winning requester's burst descriptor
    always_comb begin
        win_addr_s = addr0;
        win_len_s  = len0;
        if (winner_s) begin
            win_addr_s = addr1;
            win_len_s  = len1;
        end else begin
            win_addr_s = addr0;
            win_len_s  = len0;
        end
    end

    // Next-state and output logic of the burst sequencer
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        rom_addr_d   = rom_addr_q;
        data0_d      = data0_q;
        data1_d      = data1_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        vld0_d       = 1'b0;
        vld1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d    = winner_s;
                    rom_addr_d = win_addr_s;
                    // ptr always points one word ahead of rom_addr.
                    ptr_d      = win_addr_s + ADDR_W'(1);
                    cnt_d      = win_len_s;
                    gnt0_d     = ~winner_s;
                    gnt1_d     = winner_s;
                    state_d    = READ;
                    busy_d     = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            READ: begin
                // rom_data reflects the address presented during this cycle.
                if (owner_q) begin
                    data1_d = rom_data;
                    vld1_d  = 1'b1;
                end else begin
                    data0_d = rom_data;
                    vld0_d  = 1'b1;
                end
                rom_addr_d = ptr_q;
                ptr_d      = ptr_q + ADDR_W'(1);
                cnt_d      = cnt_q - ADDR_W'(1);
                if (cnt_q == ADDR_W'(0)) begin
                    done0_d      = ~owner_q;
                    done1_d      = owner_q;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            ptr_q        <= '0;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            vld0_q       <= 1'b0;
            vld1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            vld0_q       <= vld0_d;
            vld1_q       <= vld1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign vld0     = vld0_q;
    assign vld1     = vld1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign data0    = data0_q;
    assign data1    = data1_q;
    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Sequencer and arbiter sharing the single combinational 8x4 `ROM` between two requesters. Each requester issues a burst read of 1–8 consecutive words. The block grants one requester at a time, drives the ROM address one word per cycle, and returns registered data with a valid strobe and an end-of-burst flag. It sits between the `ROM` instance and the two client blocks, and is the only driver of the ROM `addr` input.

## Interface
Parameters:
- `ADDR_W`, default 3: ROM address width; burst length field width.
- `DATA_W`, default 4: ROM data width.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req0` / `req1`  in  1  burst request; held high until the matching `gnt` pulse.
- `addr0` / `addr1`  in  ADDR_W  burst start address; sampled with the grant.
- `len0` / `len1`  in  ADDR_W  beats minus one (0 = 1 beat, 7 = 8 beats); sampled with the grant.
- `gnt0` / `gnt1`  out  1  one-cycle grant pulse.
- `vld0` / `vld1`  out  1  data beat valid for that requester.
- `data0` / `data1`  out  DATA_W  registered read data.
- `done0` / `done1`  out  1  high together with the last beat of the burst.
- `rom_addr`  out  ADDR_W  address to `ROM.addr`.
- `rom_data`  in  DATA_W  from `ROM.DATA`; combinational in `rom_addr`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has two states, IDLE and READ. Internal registers: `owner`, `ptr`, `cnt` (ADDR_W bits), and `last_owner`.
- IDLE, no request: all strobes are low; `rom_addr` holds its value.
- IDLE, at least one `req` high at an edge: the arbiter picks the winner and sets:
  - `owner` = winner, `ptr` = `addrN + 1`, `rom_addr` = `addrN`, `cnt` = `lenN`;
  - `gntN` = 1, state = READ.
- READ, each edge:
  - `data[owner]` = `rom_data`, `vld[owner]` = 1;
  - `rom_addr` = `ptr`, `ptr` = `ptr + 1`, `cnt` = `cnt - 1`.
- READ, when `cnt` == 0 at the edge: that edge also sets `done[owner]` = 1, `last_owner` = `owner`, and state = IDLE.
- Address arithmetic is modulo 2^ADDR_W: after 3'b111 the next address is 3'b000. No error is raised on wrap.
- Arbitration is decided only in IDLE. A request arriving during READ waits, and is never dropped while `req` stays high.
- If `req` is still high in IDLE after `done`, it is treated as a new request.
- The non-owner's `vld`, `gnt`, and `done` stay 0. Both `data` outputs hold their last value between beats.

## Timing
- Reset, synchronous on `rst_n` = 0:
  - State = IDLE.
  - All `gnt`, `vld`, `done`, and `busy` outputs = 0.
  - `data0` = `data1` = 0 and `rom_addr` = 0.
  - `last_owner` = 1, so requester 0 wins the first contention.
- Reset asserted mid-burst abandons the burst. No `done` is issued and there is no further `vld`.
- Latency and burst length:
  - `req` sampled at edge E0 produces `gnt` high during cycle E0→E1.
  - The first `vld` beat is high during cycle E1→E2.
  - A burst of L beats occupies edges E1..EL. `done` is high in the same cycle as beat L.
- Data is registered. `data` is the ROM word at the `rom_addr` value presented during the preceding cycle.
- Back-to-back bursts: the earliest next grant is at edge EL+1, giving exactly one IDLE cycle with no `vld` between bursts.
- `gnt` and `vld` never overlap; the first `vld` follows `gnt` by one cycle.

## Configuration
- `ROM_ARB_RR_EN` defined: round-robin arbitration. On simultaneous `req0` and `req1` in IDLE, the grant goes to the requester that is not `last_owner`.
- `ROM_ARB_RR_EN` undefined: fixed priority, where `req0` always wins simultaneous contention. `last_owner` is still tracked but unused.

## Test plan
- Single-beat read: reset, then `req0`=1, `addr0`=3'b010, `len0`=0.
  - Expect `gnt0` for 1 cycle, then `vld0`=`done0`=1 for 1 cycle with `data0` = ROM[2].
  - Expect `busy` high for exactly 1 cycle after the grant edge.
- Full wrap burst: `req1`, `addr1`=3'b110, `len1`=3.
  - Expect `vld1` on 4 consecutive cycles with `data1` = ROM[6], ROM[7], ROM[0], ROM[1].
  - Expect `done1` only on the 4th beat and `gnt0`/`vld0` = 0 throughout.
- Contention: `req0` and `req1` both high with `len`=1 each.
  - With `ROM_ARB_RR_EN`: grant order is 0, then 1, then 0 on repeated contention, with a 1-cycle gap between bursts.
  - Without the macro: requester 0 is granted every time.
- Late request: `req1` raised during requester 0's 8-beat burst from 3'b000.
  - Expect `gnt1` at the edge after `done0`'s cycle.
  - Expect requester 0's beats to be unbroken ROM[0]..ROM[7].
- Mid-burst reset: pull `rst_n` low during beat 3 of an 8-beat burst.
  - Next cycle: all outputs = 0, `rom_addr` = 0, no `done0`.
  - After reset release with `req0` held, a fresh `gnt0` follows.
